// File: rtl/dct_pkg.sv
// Shared definitions for the 1D DCT / IDCT blocks.
//   - Default coefficient / sample widths (shared with the forward DCT bench).
//   - Q12 fixed-point constants: FRAC and the +0.5 rounding bias.
//   - Engine state enum for the IDCT MAC engine.
//   - idct_coef(): Q12 cosine table C[n][k] = round(2048 * c(k) * cos((2n+1)k*pi/16)).
package dct_pkg;

    localparam int DCT_IN_W   = 12;
    localparam int DCT_OUT_W  = 9;
    localparam int FRAC       = 12;
    localparam int ROUND_BIAS = 1 << (FRAC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StRnd,
        StOut
    } eng_state_e;

    // Signed 13-bit Q12 constant for output sample n, coefficient k.
    // The angle (2n+1)k*pi/16 is reduced modulo 2*pi (32 sixteenths), folded
    // into the first quadrant, and looked up in the 7-entry cosine magnitude table.
    function automatic logic signed [12:0] idct_coef(input logic [2:0] n, input logic [2:0] k);
        logic [4:0]         t;
        logic [5:0]         m;
        logic               neg;
        logic signed [12:0] mag;
        t   = 5'({n, 1'b1}) * 5'(k);   // 5-bit product wraps mod 32
        m   = {1'b0, t};
        neg = 1'b0;
        if (m > 6'd16) m = 6'd32 - m;
        if (m > 6'd8) begin
            m   = 6'd16 - m;
            neg = 1'b1;
        end
        case (m)
            6'd1:    mag = 13'sd2009;
            6'd2:    mag = 13'sd1892;
            6'd3:    mag = 13'sd1703;
            6'd4:    mag = 13'sd1448;
            6'd5:    mag = 13'sd1138;
            6'd6:    mag = 13'sd784;
            6'd7:    mag = 13'sd400;
            default: mag = 13'sd0;
        endcase
        // DC column carries the extra 1/sqrt(2).
        if (k == 3'd0) begin
            mag = 13'sd1448;
            neg = 1'b0;
        end
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/idct_round_sat.sv
// Combinational rounding and saturation of one accumulator value.
//   acc : signed ACC_W Q12 accumulator
//   y   : signed OUT_W sample = sat((acc + 2048) >>> 12)
// The arithmetic shift floors, so with the +0.5 bias this is round-half-up.
module idct_round_sat
    import dct_pkg::*;
#(
    parameter int ACC_W = DCT_IN_W + 16,
    parameter int OUT_W = DCT_OUT_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] BIAS    = ACC_W'(ROUND_BIAS);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        biased  = acc + BIAS;
        shifted = biased >>> FRAC;
        if (shifted > SAT_MAX) begin
            y = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            y = SAT_MIN[OUT_W-1:0];
        end else begin
            y = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/idct8_mac.sv
// 8-point inverse DCT with a serial coefficient input and parallel sample output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : coefficient stream handshake, in_data = X[k], X0 first
//   out_valid/out_ready : block handshake, y0..y7 = x[0]..x[7] (saturated)
//   busy                : engine active or input buffer holding coefficients
// A one-block input buffer collects the next block while the MAC engine works
// on the current one. The engine runs 8 MAC cycles (one coefficient per cycle,
// 8 lanes in parallel), one round/saturate cycle, then holds the result.
module idct8_mac
    import dct_pkg::*;
#(
    parameter int IN_W  = DCT_IN_W,
    parameter int OUT_W = DCT_OUT_W,
    parameter int ACC_W = IN_W + 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y0,
    output logic signed [OUT_W-1:0] y1,
    output logic signed [OUT_W-1:0] y2,
    output logic signed [OUT_W-1:0] y3,
    output logic signed [OUT_W-1:0] y4,
    output logic signed [OUT_W-1:0] y5,
    output logic signed [OUT_W-1:0] y6,
    output logic signed [OUT_W-1:0] y7,
    output logic                    busy
);

    // Input buffer
    logic signed [IN_W-1:0] buf_q [8];
    logic        [2:0]      idx_q;
    logic                   buf_full_q;

    // Engine
    eng_state_e              state_q;
    logic        [2:0]       k_q;
    logic signed [IN_W-1:0]  coef_q [8];
    logic signed [ACC_W-1:0] acc_q  [8];
    logic signed [OUT_W-1:0] y_q    [8];
    logic                    out_valid_q;

    logic                    accept;
    logic                    transfer;
    logic signed [IN_W-1:0]  cur_coef;
    logic signed [ACC_W-1:0] prod [8];
    logic signed [OUT_W-1:0] y_rs [8];

    assign in_ready = !buf_full_q;
    assign accept   = in_valid && in_ready;
    // accept needs !buf_full and transfer needs buf_full, so they never coincide.
    assign transfer = buf_full_q && (state_q == StIdle);
    assign cur_coef = coef_q[k_q];

    // Operands are widened before multiplying so the product keeps full precision.
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            prod[n] = ACC_W'(cur_coef) * ACC_W'(idct_coef(3'(n), k_q));
        end
    end

    for (genvar n = 0; n < 8; n++) begin : g_rs
        idct_round_sat #(
            .ACC_W(ACC_W),
            .OUT_W(OUT_W)
        ) u_rs (
            .acc(acc_q[n]),
            .y  (y_rs[n])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= 3'd0;
            buf_full_q <= 1'b0;
            for (int i = 0; i < 8; i++) buf_q[i] <= '0;
        end else if (accept) begin
            buf_q[idx_q] <= signed'(in_data);
            idx_q        <= idx_q + 3'd1;
            if (idx_q == 3'd7) buf_full_q <= 1'b1;
        end else if (transfer) begin
            buf_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= 3'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                coef_q[i] <= '0;
                acc_q[i]  <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (transfer) begin
                        for (int i = 0; i < 8; i++) begin
                            coef_q[i] <= buf_q[i];
                            acc_q[i]  <= '0;
                        end
                        k_q     <= 3'd0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    for (int i = 0; i < 8; i++) acc_q[i] <= acc_q[i] + prod[i];
                    k_q <= k_q + 3'd1;
                    if (k_q == 3'd7) state_q <= StRnd;
                end
                StRnd: begin
                    for (int i = 0; i < 8; i++) y_q[i] <= y_rs[i];
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    // A waiting full buffer is transferred on the following edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle) || buf_full_q || (idx_q != 3'd0);
    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign y3 = y_q[3];
    assign y4 = y_q[4];
    assign y5 = y_q[5];
    assign y6 = y_q[6];
    assign y7 = y_q[7];

endmodule

// File: tb/tb_idct8_mac.sv
// Directed self-checking bench for idct8_mac.
module tb_idct8_mac;

    localparam int IN_W  = 12;
    localparam int OUT_W = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic            busy;
    logic [OUT_W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [OUT_W-1:0] y_obs [8];

    int asserts = 0;
    int fails   = 0;

    int zero_x [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int dc_x   [8] = '{283, 0, 0, 0, 0, 0, 0, 0};
    int ac_x   [8] = '{0, 100, 0, 0, 0, 0, 0, 0};
    int pos_x  [8] = '{2047, 0, 0, 0, 0, 0, 0, 0};
    int neg_x  [8] = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    int dc_y   [8] = '{100, 100, 100, 100, 100, 100, 100, 100};
    int ac_y   [8] = '{49, 42, 28, 10, -10, -28, -42, -49};
    int pos_y  [8] = '{255, 255, 255, 255, 255, 255, 255, 255};
    int neg_y  [8] = '{-256, -256, -256, -256, -256, -256, -256, -256};

    idct8_mac #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y4       (y4),
        .y5       (y5),
        .y6       (y6),
        .y7       (y7),
        .busy     (busy)
    );

    assign y_obs[0] = y0;
    assign y_obs[1] = y1;
    assign y_obs[2] = y2;
    assign y_obs[3] = y3;
    assign y_obs[4] = y4;
    assign y_obs[5] = y5;
    assign y_obs[6] = y6;
    assign y_obs[7] = y7;

    always #5 clk = ~clk;

    // Drives 8 beats; returns at 1 time unit after the 8th accept edge.
    task automatic send_block(input int x [8]);
        for (int i = 0; i < 8; i++) begin
            in_data  = IN_W'(x[i]);
            in_valid = 1'b1;
            for (int g = 0; g < 50 && !in_ready; g++) begin
                @(posedge clk);
                #1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic take_block();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        asserts++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        asserts++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy got %b want 0", busy);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== '0) begin
                fails++; $display("FAIL reset_y%0d got %0d want 0", i, $signed(y_obs[i]));
            end
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zeros();
        int c;
        send_block(zero_x);
        wait_out(c);
        asserts++;
        if (c !== 10) begin
            fails++; $display("FAIL zeros_latency got %0d want 10", c);
        end
        asserts++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL zeros_busy got %b want 1", busy);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== '0) begin
                fails++; $display("FAIL zeros_y%0d got %0d want 0", i, $signed(y_obs[i]));
            end
        end
        take_block();
        asserts++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zeros_release got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_dc_ac();
        int c;
        send_block(dc_x);
        wait_out(c);
        asserts++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL dc_valid got %b want 1", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== OUT_W'(dc_y[i])) begin
                fails++; $display("FAIL dc_y%0d got %0d want %0d", i, $signed(y_obs[i]), dc_y[i]);
            end
        end
        take_block();
        send_block(ac_x);
        wait_out(c);
        asserts++;
        if (c !== 10) begin
            fails++; $display("FAIL ac_latency got %0d want 10", c);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== OUT_W'(ac_y[i])) begin
                fails++; $display("FAIL ac_y%0d got %0d want %0d", i, $signed(y_obs[i]), ac_y[i]);
            end
        end
        take_block();
    endtask

    task automatic test_saturation();
        int c;
        send_block(pos_x);
        wait_out(c);
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== OUT_W'(pos_y[i])) begin
                fails++;
                $display("FAIL sat_pos_y%0d got %0d want %0d", i, $signed(y_obs[i]), pos_y[i]);
            end
        end
        take_block();
        send_block(neg_x);
        wait_out(c);
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== OUT_W'(neg_y[i])) begin
                fails++;
                $display("FAIL sat_neg_y%0d got %0d want %0d", i, $signed(y_obs[i]), neg_y[i]);
            end
        end
        take_block();
    endtask

    task automatic test_backpressure();
        int c;
        out_ready = 1'b0;
        send_block(dc_x);
        wait_out(c);
        asserts++;
        if (c !== 10) begin
            fails++; $display("FAIL bp_a_latency got %0d want 10", c);
        end
        send_block(ac_x);
        asserts++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_in_ready_low got %b want 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        asserts++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL bp_a_held_valid got %b want 1", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== OUT_W'(dc_y[i])) begin
                fails++;
                $display("FAIL bp_a_held_y%0d got %0d want %0d", i, $signed(y_obs[i]), dc_y[i]);
            end
        end
        take_block();
        // Handshake edge: engine goes idle, buffer still full.
        asserts++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_bubble got valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_transfer_in_ready got %b want 1", in_ready);
        end
        wait_out(c);
        asserts++;
        if (c !== 9) begin
            fails++; $display("FAIL bp_b_latency got %0d want 9", c);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== OUT_W'(ac_y[i])) begin
                fails++; $display("FAIL bp_b_y%0d got %0d want %0d", i, $signed(y_obs[i]), ac_y[i]);
            end
        end
        take_block();
    endtask

    task automatic test_reset_mid_block();
        int c;
        int seen;
        out_ready = 1'b0;
        send_block(ac_x);
        wait_out(c);
        for (int i = 0; i < 5; i++) begin
            in_data  = IN_W'(500 + i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        asserts++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre_reset got busy=%b valid=%b want 1 1", busy, out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        asserts++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_flags got valid=%b busy=%b in_ready=%b want 0 0 1",
                     out_valid, busy, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== '0) begin
                fails++; $display("FAIL mid_reset_y%0d got %0d want 0", i, $signed(y_obs[i]));
            end
        end
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        asserts++;
        if (seen !== 0) begin
            fails++; $display("FAIL mid_no_stale_valid got %0d valid cycles want 0", seen);
        end
        send_block(dc_x);
        wait_out(c);
        asserts++;
        if (c !== 10) begin
            fails++; $display("FAIL mid_new_latency got %0d want 10", c);
        end
        for (int i = 0; i < 8; i++) begin
            asserts++;
            if (y_obs[i] !== OUT_W'(dc_y[i])) begin
                fails++;
                $display("FAIL mid_new_y%0d got %0d want %0d", i, $signed(y_obs[i]), dc_y[i]);
            end
        end
        take_block();
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_dc_ac();
        test_saturation();
        test_backpressure();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
